// File: rtl/sonic_presence_filter.sv
// Smooths raw ultrasonic distances with a power-of-two moving average and debounces FAR/NEAR/PET presence.
// Define SONIC_OUTLIER_REJECT_EN to drop samples equal to 0 or above MAX_DIST before they reach the window.
module sonic_presence_filter #(
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned PET_ON   = 511,
    parameter int unsigned PET_OFF  = 575,
    parameter int unsigned EXP_ON   = 1279,
    parameter int unsigned EXP_OFF  = 1407,
    parameter int unsigned DWELL    = 3,
    parameter int unsigned TIMEOUT  = 25000000
`ifdef SONIC_OUTLIER_REJECT_EN
    ,
    parameter int unsigned MAX_DIST = 4000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] distance,
    input  logic        dist_valid,
    output logic [19:0] avg_dist,
    output logic        avg_valid,
    output logic        expecting,
    output logic        petting,
    output logic        pet_start,
    output logic        stale,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_FAR  = 2'd0,
        ST_NEAR = 2'd1,
        ST_PET  = 2'd2
    } state_e;

    localparam int unsigned N    = 1 << AVG_LOG2;
    localparam int unsigned WINW = N * 20;
    localparam int unsigned SW   = 20 + AVG_LOG2;
    localparam int unsigned FW   = AVG_LOG2 + 1;
    localparam int unsigned TW   = $clog2(TIMEOUT + 1);
    localparam int unsigned DW   = $clog2(DWELL + 1);

    localparam logic [19:0]   PET_ON_W  = 20'(PET_ON);
    localparam logic [19:0]   PET_OFF_W = 20'(PET_OFF);
    localparam logic [19:0]   EXP_ON_W  = 20'(EXP_ON);
    localparam logic [19:0]   EXP_OFF_W = 20'(EXP_OFF);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_PRE   = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DWELL_W   = DW'(DWELL);

    // dist_valid is a one-cycle strobe with no back-pressure: every strobe is consumed on its clk edge.
    logic [WINW-1:0] win_q, win_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic            upd_q, upd_d;
    logic [19:0]     avg_dist_q, avg_dist_d;
    logic            avg_valid_q, avg_valid_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            stale_q, stale_d;
    state_e          state_q, state_d;
    state_e          pend_q, pend_d;
    state_e          cand;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            expecting_q, expecting_d;
    logic            petting_q, petting_d;
    logic            pet_start_q, pet_start_d;
    logic            accept;
    logic            tmo_hit;

    always_comb begin
`ifdef SONIC_OUTLIER_REJECT_EN
        accept = dist_valid && (distance != 20'd0) && (distance <= 20'(MAX_DIST));
`else
        accept = dist_valid;
`endif
        // The stale event fires exactly once, on the edge where the idle count reaches TIMEOUT.
        tmo_hit = !dist_valid && (tmo_q == TMO_PRE);

        tmo_d   = tmo_q;
        stale_d = stale_q;
        if (dist_valid) begin
            tmo_d   = '0;
            stale_d = 1'b0;
        end else begin
            if (tmo_q != TMO_MAX) tmo_d = tmo_q + TW'(1);
            if (tmo_hit) stale_d = 1'b1;
        end

        win_d  = win_q;
        sum_d  = sum_q;
        fill_d = fill_q;
        upd_d  = accept;
        if (accept) begin
            sum_d = sum_q + SW'(distance) - SW'(win_q[WINW-1 -: 20]);
            win_d = WINW'({win_q, distance});
            if (fill_q != FILL_FULL) fill_d = fill_q + FW'(1);
        end else if (tmo_hit) begin
            fill_d = '0;
        end

        avg_valid_d = upd_q && (fill_q == FILL_FULL) && !tmo_hit;
        avg_dist_d  = avg_valid_d ? sum_q[SW-1:AVG_LOG2] : avg_dist_q;
    end

    // Candidate state with hysteresis: the exit threshold depends on where we are now.
    always_comb begin
        cand = ST_FAR;
        case (state_q)
            ST_FAR: begin
                if (avg_dist_q < PET_ON_W)      cand = ST_PET;
                else if (avg_dist_q < EXP_ON_W) cand = ST_NEAR;
                else                            cand = ST_FAR;
            end
            ST_NEAR: begin
                if (avg_dist_q < PET_ON_W)       cand = ST_PET;
                else if (avg_dist_q < EXP_OFF_W) cand = ST_NEAR;
                else                             cand = ST_FAR;
            end
            ST_PET: begin
                if (avg_dist_q < PET_OFF_W)      cand = ST_PET;
                else if (avg_dist_q < EXP_OFF_W) cand = ST_NEAR;
                else                             cand = ST_FAR;
            end
            default: cand = ST_FAR;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        dwell_d = dwell_q;
        if (tmo_hit) begin
            state_d = ST_FAR;
            pend_d  = ST_FAR;
            dwell_d = '0;
        end else if (avg_valid_q) begin
            if (cand == state_q) begin
                dwell_d = '0;
            end else if (cand == pend_q) begin
                if ((dwell_q + DW'(1)) >= DWELL_W) begin
                    state_d = cand;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end else begin
                pend_d = cand;
                if (DWELL == 1) begin
                    state_d = cand;
                    dwell_d = '0;
                end else begin
                    dwell_d = DW'(1);
                end
            end
        end

        expecting_d = (state_d != ST_FAR);
        petting_d   = (state_d == ST_PET);
        pet_start_d = (state_d == ST_PET) && (state_q != ST_PET);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q       <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            upd_q       <= 1'b0;
            avg_dist_q  <= '0;
            avg_valid_q <= 1'b0;
            tmo_q       <= '0;
            stale_q     <= 1'b0;
            state_q     <= ST_FAR;
            pend_q      <= ST_FAR;
            dwell_q     <= '0;
            expecting_q <= 1'b0;
            petting_q   <= 1'b0;
            pet_start_q <= 1'b0;
        end else begin
            win_q       <= win_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            upd_q       <= upd_d;
            avg_dist_q  <= avg_dist_d;
            avg_valid_q <= avg_valid_d;
            tmo_q       <= tmo_d;
            stale_q     <= stale_d;
            state_q     <= state_d;
            pend_q      <= pend_d;
            dwell_q     <= dwell_d;
            expecting_q <= expecting_d;
            petting_q   <= petting_d;
            pet_start_q <= pet_start_d;
        end
    end

    assign avg_dist  = avg_dist_q;
    assign avg_valid = avg_valid_q;
    assign expecting = expecting_q;
    assign petting   = petting_q;
    assign pet_start = pet_start_q;
    assign stale     = stale_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sonic_presence_filter.sv
// Randomized bench for sonic_presence_filter against a queue-based mean / hysteresis / dwell model.
module tb_sonic_presence_filter;

    localparam int AVG_LOG2 = 2;
    localparam int PET_ON   = 511;
    localparam int PET_OFF  = 575;
    localparam int EXP_ON   = 1279;
    localparam int EXP_OFF  = 1407;
    localparam int DWELL    = 3;
    localparam int TIMEOUT  = 50;
    localparam int WIN      = 1 << AVG_LOG2;
`ifdef SONIC_OUTLIER_REJECT_EN
    localparam int MAX_DIST = 4000;
`endif

    localparam int M_FAR  = 0;
    localparam int M_NEAR = 1;
    localparam int M_PET  = 2;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] distance = '0;
    logic        dist_valid = 1'b0;
    logic [19:0] avg_dist;
    logic        avg_valid;
    logic        expecting;
    logic        petting;
    logic        pet_start;
    logic        stale;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    sonic_presence_filter #(
        .AVG_LOG2(AVG_LOG2),
        .PET_ON  (PET_ON),
        .PET_OFF (PET_OFF),
        .EXP_ON  (EXP_ON),
        .EXP_OFF (EXP_OFF),
        .DWELL   (DWELL),
        .TIMEOUT (TIMEOUT)
`ifdef SONIC_OUTLIER_REJECT_EN
        ,
        .MAX_DIST(MAX_DIST)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .distance  (distance),
        .dist_valid(dist_valid),
        .avg_dist  (avg_dist),
        .avg_valid (avg_valid),
        .expecting (expecting),
        .petting   (petting),
        .pet_start (pet_start),
        .stale     (stale),
        .dbg_state (dbg_state)
    );

    // scoreboard / reference model
    int n_vec = 0;
    int n_err = 0;
    int m_q[$];
    int m_fill, m_avg, m_state, m_pend, m_cnt;
    bit m_stale;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_fill  = 0;
        m_avg   = 0;
        m_state = M_FAR;
        m_pend  = M_FAR;
        m_cnt   = 0;
        m_stale = 1'b0;
    endfunction

    // Apply one averaged sample to the debounced classifier; returns 1 on entry to PET.
    function automatic bit step_dwell(input int a);
        int c;
        int lim_pet;
        int lim_exp;
        lim_pet = (m_state == M_PET) ? PET_OFF : PET_ON;
        lim_exp = (m_state == M_FAR) ? EXP_ON : EXP_OFF;
        if (a < lim_pet)      c = M_PET;
        else if (a < lim_exp) c = M_NEAR;
        else                  c = M_FAR;
        if (c == m_state) begin
            m_cnt = 0;
            return 1'b0;
        end
        if (c == m_pend) m_cnt++;
        else begin
            m_pend = c;
            m_cnt  = 1;
        end
        if (m_cnt >= DWELL) begin
            m_cnt   = 0;
            m_state = c;
            return (c == M_PET);
        end
        return 1'b0;
    endfunction

    // driver tasks
    task automatic do_reset();
        rst        = 1'b0;
        dist_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_avg_dist", 32'(avg_dist), 0);
        check_eq("rst_avg_valid", 32'(avg_valid), 0);
        check_eq("rst_expecting", 32'(expecting), 0);
        check_eq("rst_petting", 32'(petting), 0);
        check_eq("rst_pet_start", 32'(pet_start), 0);
        check_eq("rst_stale", 32'(stale), 0);
        rst = 1'b1;
        model_reset();
    endtask

    // One strobe, then `idle` quiet cycles, checking every output after each edge.
    task automatic send(input int d, input int idle);
        bit acc;
        bit v;
        bit ps;
        int avg;
        int sum;
        distance   = 20'(d);
        dist_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dist_valid = 1'b0;
        distance   = 20'($urandom_range(0, 4095));
        m_stale    = 1'b0;
        acc = 1'b1;
`ifdef SONIC_OUTLIER_REJECT_EN
        if (d == 0 || d > MAX_DIST) acc = 1'b0;
`endif
        v   = 1'b0;
        ps  = 1'b0;
        avg = 0;
        if (acc) begin
            m_q.push_back(d);
            if (m_q.size() > WIN) void'(m_q.pop_front());
            if (m_fill < WIN) m_fill++;
            if (m_fill == WIN) begin
                sum = 0;
                foreach (m_q[i]) sum += m_q[i];
                avg = sum / WIN;
                v   = 1'b1;
            end
        end
        check_eq("stale_clear", 32'(stale), 0);
        for (int k = 1; k <= idle; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1 && v) m_avg = avg;
            if (k == 2 && v) ps = step_dwell(avg);
            if (k == TIMEOUT) begin
                m_stale = 1'b1;
                m_state = M_FAR;
                m_pend  = M_FAR;
                m_cnt   = 0;
                m_fill  = 0;
            end
            check_eq("avg_valid", 32'(avg_valid), 32'(k == 1 && v));
            check_eq("avg_dist", 32'(avg_dist), 32'(m_avg));
            check_eq("expecting", 32'(expecting), 32'(m_state != M_FAR));
            check_eq("petting", 32'(petting), 32'(m_state == M_PET));
            check_eq("pet_start", 32'(pet_start), 32'(k == 2 && ps));
            check_eq("stale", 32'(stale), 32'(m_stale));
        end
    endtask

    task automatic send_n(input int d, input int n);
        for (int i = 0; i < n; i++) send(d, $urandom_range(2, 4));
    endtask

    initial begin
        int level;
        int cnt;
        do_reset();

        // fill, then approach from far
        send_n(300, 4);
        send(2000, 3);
        send_n(1000, 6);
        // pet entry, hysteresis hold, exit to near
        send_n(400, 6);
        send_n(540, 4);
        send_n(600, 6);
        // back to far, then a glitchy dip that must not switch state
        send_n(2000, 5);
        send(1000, 2);
        send(100, 2);
        send(100, 2);
        send(4000, 2);
        send(1100, 2);
        send(100, 2);
        // timeout boundary: one cycle short, then exactly on it, then refill
        send_n(400, 6);
        send(400, TIMEOUT - 1);
        send(400, TIMEOUT);
        send_n(300, 5);
        send_n(400, 6);
        send(400, TIMEOUT + 10);
        send_n(450, 6);
        // mid-operation reset
        do_reset();
        send_n(350, 6);
        // out-of-range samples among steady readings
        send_n(300, 4);
        send(0, 3);
        send(5000, 3);
        send_n(300, 2);

        // random segments around the thresholds
        for (int s = 0; s < 40; s++) begin
            level = $urandom_range(200, 1800);
            cnt   = $urandom_range(3, 8);
            for (int i = 0; i < cnt; i++) begin
                if ($urandom_range(0, 20) == 0) send(level, TIMEOUT + $urandom_range(0, 5));
                else if ($urandom_range(0, 15) == 0) send($urandom_range(0, 1) == 1 ? 0 : 4500, $urandom_range(2, 5));
                else send(level + $urandom_range(0, 100) - 50, $urandom_range(2, 5));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
